// File: rtl/dual_issue_route.sv
// dual_issue_route: post-fetch issue router. Classifies each instruction of
// the fetched pair as even-pipe or odd-pipe, dual-issues legal pairs and
// splits conflicting pairs over two cycles while holding fetch.
// Optional build macro: DUAL_ISSUE_DEP_CHECK_EN (also split a mixed-class
// pair when the second instruction reads the first one's target register).
// Bit numbering note: instruction bit 0 is the MSB, so inst[0:k] in the ISA
// manual maps to inst[31:31-k] here.
// Handshake: inst_valid qualifies the input pair; when stall_fetch is high
// fetch must present the same pair again next cycle; otherwise the pair is
// consumed at the clock edge.
module dual_issue_route #(
  parameter logic [31:0] NOP_EVEN = 32'h4020_0000,
  parameter logic [31:0] NOP_ODD  = 32'h0020_0000,
  parameter int          PC_W     = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inst_valid,
  input  logic [31:0]     first_inst,
  input  logic [31:0]     second_inst,
  input  logic [PC_W-1:0] pc_input,
  input  logic            branch_taken,
  input  logic            stall_in,
  output logic            stall_fetch,
  output logic [31:0]     even_inst,
  output logic [31:0]     odd_inst,
  output logic            even_valid,
  output logic            odd_valid,
  output logic [PC_W-1:0] even_pc,
  output logic [PC_W-1:0] odd_pc,
  output logic            state_dbg
);

  typedef enum logic {READY = 1'b0, SPLIT = 1'b1} state_t;

  state_t          state, n_state;
  logic [31:0]     held_inst, n_held_inst;
  logic [PC_W-1:0] held_pc, n_held_pc;

  logic [31:0]     n_even_inst, n_odd_inst;
  logic            n_even_valid, n_odd_valid;
  logic [PC_W-1:0] n_even_pc, n_odd_pc;

  // lnop sits in the odd group although its opcode does not start with 001
  function automatic logic is_odd(input logic [31:0] inst);
    return (inst[31:29] == 3'b001) || (inst[31:21] == 11'b0) ||
           (inst[31:21] == 11'b00000000001);
  endfunction

  // nop and lnop are fillers: routed normally but never flagged valid
  function automatic logic is_real(input logic [31:0] inst);
    return (inst[31:21] != 11'b01000000001) && (inst[31:21] != 11'b00000000001);
  endfunction

  logic first_odd, second_odd, held_odd, split_need;

  assign first_odd  = is_odd(first_inst);
  assign second_odd = is_odd(second_inst);
  assign held_odd   = is_odd(held_inst);

`ifdef DUAL_ISSUE_DEP_CHECK_EN
  // Stores and conditional branches share the 0010 opcode prefix; stop has
  // an all-zero opcode; nop/lnop write nothing.
  logic first_writes, dep_hit;
  assign first_writes = (first_inst[31:28] != 4'b0010) &&
                        (first_inst[31:21] != 11'b0) && is_real(first_inst);
  assign dep_hit = first_writes &&
                   ((second_inst[13:7] == first_inst[6:0]) ||
                    (second_inst[20:14] == first_inst[6:0]));
  assign split_need = (first_odd == second_odd) || dep_hit;
`else
  assign split_need = (first_odd == second_odd);
`endif

  // Fetch hold: downstream stall, or the conflict cycle of a split pair
  assign stall_fetch = !reset && !branch_taken &&
                       (stall_in || ((state == READY) && inst_valid && split_need));

  assign state_dbg = state;

  // Next-state and next-output selection for an unstalled, unflushed cycle
  always_comb begin
    n_state      = state;
    n_held_inst  = held_inst;
    n_held_pc    = held_pc;
    n_even_inst  = NOP_EVEN;
    n_odd_inst   = NOP_ODD;
    n_even_valid = 1'b0;
    n_odd_valid  = 1'b0;
    n_even_pc    = '0;
    n_odd_pc     = '0;
    if (state == SPLIT) begin
      if (held_odd) begin
        n_odd_inst  = held_inst;
        n_odd_valid = is_real(held_inst);
        n_odd_pc    = is_real(held_inst) ? held_pc : '0;
      end else begin
        n_even_inst  = held_inst;
        n_even_valid = is_real(held_inst);
        n_even_pc    = is_real(held_inst) ? held_pc : '0;
      end
      n_held_inst = '0;
      n_held_pc   = '0;
      n_state     = READY;
    end else if (inst_valid) begin
      if (first_odd) begin
        n_odd_inst  = first_inst;
        n_odd_valid = is_real(first_inst);
        n_odd_pc    = is_real(first_inst) ? pc_input : '0;
      end else begin
        n_even_inst  = first_inst;
        n_even_valid = is_real(first_inst);
        n_even_pc    = is_real(first_inst) ? pc_input : '0;
      end
      if (split_need) begin
        n_held_inst = second_inst;
        n_held_pc   = pc_input + PC_W'(4);
        n_state     = SPLIT;
      end else if (second_odd) begin
        n_odd_inst  = second_inst;
        n_odd_valid = is_real(second_inst);
        n_odd_pc    = is_real(second_inst) ? pc_input + PC_W'(4) : '0;
      end else begin
        n_even_inst  = second_inst;
        n_even_valid = is_real(second_inst);
        n_even_pc    = is_real(second_inst) ? pc_input + PC_W'(4) : '0;
      end
    end
  end

  // State and output registers; flush outranks stall, reset outranks all
  always_ff @(posedge clock) begin
    if (reset || branch_taken) begin
      state      <= READY;
      held_inst  <= '0;
      held_pc    <= '0;
      even_inst  <= NOP_EVEN;
      odd_inst   <= NOP_ODD;
      even_valid <= 1'b0;
      odd_valid  <= 1'b0;
      even_pc    <= '0;
      odd_pc     <= '0;
    end else if (!stall_in) begin
      state      <= n_state;
      held_inst  <= n_held_inst;
      held_pc    <= n_held_pc;
      even_inst  <= n_even_inst;
      odd_inst   <= n_odd_inst;
      even_valid <= n_even_valid;
      odd_valid  <= n_odd_valid;
      even_pc    <= n_even_pc;
      odd_pc     <= n_odd_pc;
    end
  end

endmodule

// File: tb/tb_dual_issue_route.sv
// tb_dual_issue_route: directed vectors for dual_issue_route; expected
// output records are queued by the driver and popped by a monitor one
// cycle later.
module tb_dual_issue_route;

  localparam logic [31:0] NOP_E = 32'h4020_0000;
  localparam logic [31:0] NOP_O = 32'h0020_0000;
  localparam int          OUT_W = 130;

  // Hand-picked encodings (class noted)
  localparam logic [31:0] A0   = 32'h1800_0103; // a, EVEN
  localparam logic [31:0] A1   = 32'h1800_0185; // a, EVEN
  localparam logic [31:0] LD   = 32'h3400_0204; // lqd, ODD
  localparam logic [31:0] ST   = 32'h2400_0001; // stqd, ODD
  localparam logic [31:0] STOP = 32'h0000_0000; // stop, ODD
  localparam logic [31:0] LNOP = 32'h0020_0000; // lnop, ODD, not valid
  localparam logic [31:0] AH5  = 32'h1900_0005; // ah rt=5, EVEN
  localparam logic [31:0] LDR5 = 32'h3400_0280; // lqd ra=5, ODD

  // clock / reset
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inst_valid = 1'b0;
  logic [31:0] first_inst = '0, second_inst = '0, pc_input = '0;
  logic        branch_taken = 1'b0, stall_in = 1'b0;
  logic        stall_fetch, even_valid, odd_valid, state_dbg;
  logic [31:0] even_inst, odd_inst, even_pc, odd_pc;

  always #5 clock = ~clock;

  dual_issue_route dut (
    .clock(clock), .reset(reset), .inst_valid(inst_valid),
    .first_inst(first_inst), .second_inst(second_inst), .pc_input(pc_input),
    .branch_taken(branch_taken), .stall_in(stall_in),
    .stall_fetch(stall_fetch), .even_inst(even_inst), .odd_inst(odd_inst),
    .even_valid(even_valid), .odd_valid(odd_valid),
    .even_pc(even_pc), .odd_pc(odd_pc), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  logic [OUT_W-1:0] exp_q[$];

  function automatic logic [OUT_W-1:0] mk(input logic [31:0] ei, input logic ev,
                                          input logic [31:0] epc, input logic [31:0] oi,
                                          input logic ov, input logic [31:0] opc);
    return {ei, ev, epc, oi, ov, opc};
  endfunction

  logic [OUT_W-1:0] fill;
  assign fill = mk(NOP_E, 1'b0, 32'h0, NOP_O, 1'b0, 32'h0);

  // driver: apply one cycle of inputs at negedge, check stall_fetch, queue result
  task automatic drive(input string name, input logic rst, input logic iv,
                       input logic [31:0] f, input logic [31:0] s, input logic [31:0] pc,
                       input logic bt, input logic st, input logic exp_stall,
                       input logic [OUT_W-1:0] exp);
    @(negedge clock);
    reset = rst; inst_valid = iv; first_inst = f; second_inst = s;
    pc_input = pc; branch_taken = bt; stall_in = st;
    #1;
    checks++;
    if (stall_fetch !== exp_stall) begin
      failures++;
      $display("FAIL %s stall_fetch got=%b want=%b", name, stall_fetch, exp_stall);
    end
    exp_q.push_back(exp);
  endtask

  // scoreboard monitor: outputs settle just after each posedge
  initial begin
    logic [OUT_W-1:0] want, got;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        got  = {even_inst, even_valid, even_pc, odd_inst, odd_valid, odd_pc};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL outputs got even=%h/%b/%h odd=%h/%b/%h want even=%h/%b/%h odd=%h/%b/%h",
                   got[129:98], got[97], got[96:65], got[64:33], got[32], got[31:0],
                   want[129:98], want[97], want[96:65], want[64:33], want[32], want[31:0]);
        end
      end
    end
  end

  initial begin
    // reset held two cycles
    drive("reset0", 1, 0, 0, 0, 0, 0, 0, 0, fill);
    drive("reset1", 1, 0, 0, 0, 0, 0, 0, 0, fill);
    drive("idle",   0, 0, 0, 0, 0, 0, 0, 0, fill);

    // dual issue, even first
    drive("dual", 0, 1, A0, LD, 32'h10, 0, 0, 0, mk(A0, 1, 32'h10, LD, 1, 32'h14));
    // swapped: odd first
    drive("swap", 0, 1, LD, A1, 32'h20, 0, 0, 0, mk(A1, 1, 32'h24, LD, 1, 32'h20));

    // even/even conflict: fetch holds the pair for the split cycle
    drive("conf_e1", 0, 1, A0, A1, 32'h30, 0, 0, 1, mk(A0, 1, 32'h30, NOP_O, 0, 0));
    drive("conf_e2", 0, 1, A0, A1, 32'h30, 0, 0, 0, mk(A1, 1, 32'h34, NOP_O, 0, 0));
    // odd/odd conflict
    drive("conf_o1", 0, 1, LD, ST, 32'h40, 0, 0, 1, mk(NOP_E, 0, 0, LD, 1, 32'h40));
    drive("conf_o2", 0, 1, LD, ST, 32'h40, 0, 0, 0, mk(NOP_E, 0, 0, ST, 1, 32'h44));

    // flush while in SPLIT drops the held instruction
    drive("flush1", 0, 1, A0, A1, 32'h50, 0, 0, 1, mk(A0, 1, 32'h50, NOP_O, 0, 0));
    drive("flush2", 0, 1, A0, A1, 32'h50, 1, 0, 0, fill);
    drive("flush3", 0, 0, 0, 0, 0, 0, 0, 0, fill);

    // stall_in freezes outputs in READY
    drive("stl_r1", 0, 1, A0, LD, 32'h60, 0, 0, 0, mk(A0, 1, 32'h60, LD, 1, 32'h64));
    drive("stl_r2", 0, 1, A1, ST, 32'h68, 0, 1, 1, mk(A0, 1, 32'h60, LD, 1, 32'h64));
    drive("stl_r3", 0, 0, 0, 0, 0, 0, 0, 0, fill);

    // stall_in during SPLIT keeps the held instruction
    drive("stl_s1", 0, 1, A0, A1, 32'h70, 0, 0, 1, mk(A0, 1, 32'h70, NOP_O, 0, 0));
    drive("stl_s2", 0, 1, A0, A1, 32'h70, 0, 1, 1, mk(A0, 1, 32'h70, NOP_O, 0, 0));
    drive("stl_s3", 0, 1, A0, A1, 32'h70, 0, 0, 0, mk(A1, 1, 32'h74, NOP_O, 0, 0));

    // branch_taken wins over stall_in
    drive("bt_st0", 0, 1, A0, LD, 32'h78, 0, 0, 0, mk(A0, 1, 32'h78, LD, 1, 32'h7C));
    drive("bt_st1", 0, 1, A0, LD, 32'h80, 1, 1, 0, fill);

    // stop is a real odd instruction; lnop is odd but not valid
    drive("stop", 0, 1, A0, STOP, 32'h90, 0, 0, 0, mk(A0, 1, 32'h90, STOP, 1, 32'h94));
    drive("lnop", 0, 1, LNOP, A0, 32'hA0, 0, 0, 0, mk(A0, 1, 32'hA4, LNOP, 0, 0));

    // reset in SPLIT: held instruction never issues
    drive("rst_s1", 0, 1, A0, A1, 32'hB0, 0, 0, 1, mk(A0, 1, 32'hB0, NOP_O, 0, 0));
    drive("rst_s2", 1, 1, A0, A1, 32'hB0, 0, 0, 0, fill);
    drive("rst_s3", 0, 0, 0, 0, 0, 0, 0, 0, fill);

    // intra-pair dependence: ah rt=5 followed by lqd ra=5
`ifdef DUAL_ISSUE_DEP_CHECK_EN
    drive("dep1", 0, 1, AH5, LDR5, 32'hC0, 0, 0, 1, mk(AH5, 1, 32'hC0, NOP_O, 0, 0));
    drive("dep2", 0, 1, AH5, LDR5, 32'hC0, 0, 0, 0, mk(NOP_E, 0, 0, LDR5, 1, 32'hC4));
`else
    drive("dep", 0, 1, AH5, LDR5, 32'hC0, 0, 0, 0, mk(AH5, 1, 32'hC0, LDR5, 1, 32'hC4));
`endif
    drive("tail", 0, 0, 0, 0, 0, 0, 0, 0, fill);

    // drain: every queued expectation must be consumed within a bounded wait
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
